// File: rtl/wave_capture_buf_if.sv
// Bundle of capture, readback and status signals for wave_capture_buf.
// The decim signal exists only when WAVE_CAP_DECIM_EN is defined.
interface wave_capture_buf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic              arm;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_din;
  logic              trig;
`ifdef WAVE_CAP_DECIM_EN
  logic [7:0]        decim;
`endif
  logic              rd_en;
  logic [ADDR_W-1:0] rd_offset;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;

  modport master (
    output arm,
    output sample_valid,
    output sample_din,
    output trig,
`ifdef WAVE_CAP_DECIM_EN
    output decim,
`endif
    output rd_en,
    output rd_offset,
    input  rd_data,
    input  rd_valid,
    input  busy,
    input  done,
    input  trig_addr
  );

  modport slave (
    input  arm,
    input  sample_valid,
    input  sample_din,
    input  trig,
`ifdef WAVE_CAP_DECIM_EN
    input  decim,
`endif
    input  rd_en,
    input  rd_offset,
    output rd_data,
    output rd_valid,
    output busy,
    output done,
    output trig_addr
  );
endinterface

// File: rtl/wave_capture_buf.sv
// Triggered circular waveform capture into block RAM with pre-trigger history
// and oldest-first logical readback. Optional decimation: WAVE_CAP_DECIM_EN.
module wave_capture_buf #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int PRE_DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  wave_capture_buf_if.slave  bus
);
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
  localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRE_DEPTH);
  localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_A   = ADDR_W'(POST_LEN);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  generate
    if (PRE_DEPTH < 0 || PRE_DEPTH > DEPTH - 1) begin : g_bad_pre_depth
      $error("wave_capture_buf: PRE_DEPTH must lie in 0 .. DEPTH-1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_in_capture;
  logic              w_gate;
  logic              w_accept;
  logic              w_trig_hit;
  logic              w_busy_next;
  logic              w_done_next;
  logic [ADDR_W-1:0] w_rd_addr;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

`ifdef WAVE_CAP_DECIM_EN
  logic [7:0]        r_decim;
  logic [7:0]        r_decim_cnt;
`endif

  always_comb begin
    w_in_capture = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
`ifdef WAVE_CAP_DECIM_EN
    w_gate = (r_decim_cnt == 8'd0);
`else
    w_gate = 1'b1;
`endif
    // With no history to collect, PRE is a one-cycle pass-through that
    // stores nothing, so the first sample after it can be the trigger.
    w_accept = bus.sample_valid && w_in_capture && w_gate && !bus.arm &&
               !((r_state == S_PRE) && (PRE_DEPTH == 0));
    w_trig_hit = w_accept && (r_state == S_ARMED) && bus.trig;

    w_state_next = r_state;
    if (bus.arm) begin
      w_state_next = S_PRE;
    end else begin
      case (r_state)
        S_PRE: begin
          if ((PRE_DEPTH == 0) || (w_accept && (r_pre_cnt == PRE_LAST)))
            w_state_next = S_ARMED;
        end
        S_ARMED: begin
          if (w_trig_hit)
            w_state_next = (POST_LEN == 0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (w_accept && (r_post_cnt == ONE_A))
            w_state_next = S_DONE;
        end
        default: w_state_next = r_state;
      endcase
    end

    w_busy_next = (w_state_next == S_PRE) || (w_state_next == S_ARMED) ||
                  (w_state_next == S_POST);
    w_done_next = (w_state_next == S_DONE);
  end

  // Oldest sample sits PRE_DEPTH slots behind the trigger; wrap is free.
  assign w_rd_addr = r_trig_addr - PRE_A + bus.rd_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ptr    <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en)
        r_rd_data <= r_mem[w_rd_addr];

      if (bus.arm) begin
        r_wr_ptr    <= '0;
        r_pre_cnt   <= '0;
        r_post_cnt  <= '0;
        r_trig_addr <= '0;
      end else begin
        if (w_accept)
          r_wr_ptr <= r_wr_ptr + ONE_A;
        if (w_accept && (r_state == S_PRE))
          r_pre_cnt <= r_pre_cnt + ONE_A;
        if (w_trig_hit) begin
          r_trig_addr <= r_wr_ptr;
          r_post_cnt  <= POST_A;
        end else if (w_accept && (r_state == S_POST)) begin
          r_post_cnt <= r_post_cnt - ONE_A;
        end
      end
    end
  end

`ifdef WAVE_CAP_DECIM_EN
  // Gate opens on the first valid sample after arm, then every decim+1 valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decim     <= 8'd0;
      r_decim_cnt <= 8'd0;
    end else if (bus.arm) begin
      r_decim     <= bus.decim;
      r_decim_cnt <= 8'd0;
    end else if (bus.sample_valid && w_in_capture) begin
      r_decim_cnt <= (r_decim_cnt == r_decim) ? 8'd0 : r_decim_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[r_wr_ptr] <= bus.sample_din;
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.trig_addr = r_trig_addr;
endmodule

// File: tb/tb_wave_capture_buf.sv
// Directed bench for wave_capture_buf: two instances (PRE_DEPTH 4 and 0),
// readback checked through an expected-data scoreboard queue per instance.
module tb_wave_capture_buf;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_capture_buf_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  wave_capture_buf_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  wave_capture_buf #(.DATA_W(DW), .ADDR_W(AW), .PRE_DEPTH(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  wave_capture_buf #(.DATA_W(DW), .ADDR_W(AW), .PRE_DEPTH(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  logic [DW-1:0] exp_a_v;
  logic [DW-1:0] exp_b_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifa.rd_valid) begin
      checks++;
      assert (exp_a_q.size() > 0) else begin
        errors++;
        $error("FAIL rd_a_unexpected observed %0h expected no read", ifa.rd_data);
      end
      if (exp_a_q.size() > 0) begin
        exp_a_v = exp_a_q.pop_front();
        checks++;
        assert (ifa.rd_data === exp_a_v) else begin
          errors++;
          $error("FAIL rd_a_data observed %0h expected %0h", ifa.rd_data, exp_a_v);
        end
        $display("read a: data %0d expected %0d", ifa.rd_data, exp_a_v);
      end
    end
    if (rst_n && ifb.rd_valid) begin
      checks++;
      assert (exp_b_q.size() > 0) else begin
        errors++;
        $error("FAIL rd_b_unexpected observed %0h expected no read", ifb.rd_data);
      end
      if (exp_b_q.size() > 0) begin
        exp_b_v = exp_b_q.pop_front();
        checks++;
        assert (ifb.rd_data === exp_b_v) else begin
          errors++;
          $error("FAIL rd_b_data observed %0h expected %0h", ifb.rd_data, exp_b_v);
        end
        $display("read b: data %0d expected %0d", ifb.rd_data, exp_b_v);
      end
    end
  end

  task automatic step_a(input logic v, input int d, input logic t, input logic a);
    ifa.sample_valid = v;
    ifa.sample_din   = DW'(d);
    ifa.trig         = t;
    ifa.arm          = a;
    @(posedge clk); #1;
    ifa.sample_valid = 1'b0;
    ifa.trig         = 1'b0;
    ifa.arm          = 1'b0;
  endtask

  task automatic step_b(input logic v, input int d, input logic t, input logic a);
    ifb.sample_valid = v;
    ifb.sample_din   = DW'(d);
    ifb.trig         = t;
    ifb.arm          = a;
    @(posedge clk); #1;
    ifb.sample_valid = 1'b0;
    ifb.trig         = 1'b0;
    ifb.arm          = 1'b0;
  endtask

  // Sample values equal base + index; trigger on index trig_idx or on all.
  task automatic feed_a(input int n, input int base, input int trig_idx, input logic trig_all);
    for (int i = 0; i < n; i++)
      step_a(1'b1, base + i, trig_all || (i == trig_idx), 1'b0);
  endtask

  task automatic read_a(input int off, input int n, input int exp0);
    for (int k = 0; k < n; k++) begin
      exp_a_q.push_back(DW'(exp0 + k));
      ifa.rd_en     = 1'b1;
      ifa.rd_offset = AW'(off + k);
      @(posedge clk); #1;
    end
    ifa.rd_en = 1'b0;
  endtask

  task automatic read_b(input int off, input int exp);
    exp_b_q.push_back(DW'(exp));
    ifb.rd_en     = 1'b1;
    ifb.rd_offset = AW'(off);
    @(posedge clk); #1;
    ifb.rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 10; c++) begin
      if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_drain"}, 32'(exp_a_q.size() + exp_b_q.size()), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rd_valid_pulse"}, {31'd0, ifa.rd_valid | ifb.rd_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.arm = 0; ifa.sample_valid = 0; ifa.sample_din = 0; ifa.trig = 0;
    ifa.rd_en = 0; ifa.rd_offset = 0;
    ifb.arm = 0; ifb.sample_valid = 0; ifb.sample_din = 0; ifb.trig = 0;
    ifb.rd_en = 0; ifb.rd_offset = 0;
`ifdef WAVE_CAP_DECIM_EN
    ifa.decim = 8'd0;
    ifb.decim = 8'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      {31'd0, ifa.busy},     32'd0);
    chk("rst_done",      {31'd0, ifa.done},     32'd0);
    chk("rst_rd_valid",  {31'd0, ifa.rd_valid}, 32'd0);
    chk("rst_trig_addr", 32'(ifa.trig_addr),    32'd0);
    chk("rst_rd_data",   32'(ifa.rd_data),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic capture: trigger on sample 10 of 22.
    step_a(1'b0, 0, 1'b0, 1'b1);
    chk("s2_busy_after_arm", {31'd0, ifa.busy}, 32'd1);
    feed_a(21, 0, 10, 1'b0);
    chk("s2_trig_addr", 32'(ifa.trig_addr), 32'd10);
    chk("s2_done_early", {31'd0, ifa.done}, 32'd0);
    step_a(1'b1, 21, 1'b0, 1'b0);
    chk("s2_done", {31'd0, ifa.done}, 32'd1);
    chk("s2_busy_clear", {31'd0, ifa.busy}, 32'd0);
    read_a(0, 16, 6);
    drain("s2");
    step_a(1'b1, 99, 1'b0, 1'b0);
    read_a(5, 1, 11);
    drain("s2_frozen");

    // Trigger held high from the start: first ARMED sample wins.
    step_a(1'b0, 0, 1'b0, 1'b1);
    feed_a(16, 0, 0, 1'b1);
    chk("s3_trig_addr", 32'(ifa.trig_addr), 32'd4);
    chk("s3_done", {31'd0, ifa.done}, 32'd1);
    read_a(0, 1, 0);
    read_a(4, 1, 4);
    drain("s3");

    // Restart during POST, then arm+trig on one edge.
    step_a(1'b0, 0, 1'b0, 1'b1);
    feed_a(13, 0, 8, 1'b0);
    step_a(1'b1, 13, 1'b0, 1'b1);
    chk("s4_busy_restart", {31'd0, ifa.busy}, 32'd1);
    chk("s4_done_restart", {31'd0, ifa.done}, 32'd0);
    feed_a(17, 14, 5, 1'b0);
    chk("s4_trig_addr", 32'(ifa.trig_addr), 32'd5);
    chk("s4_done", {31'd0, ifa.done}, 32'd1);
    read_a(0, 1, 15);
    read_a(4, 1, 19);
    read_a(15, 1, 30);
    drain("s4a");
    step_a(1'b0, 0, 1'b0, 1'b1);
    feed_a(4, 0, 99, 1'b0);
    step_a(1'b1, 4, 1'b1, 1'b1);
    chk("s4_busy_armtrig", {31'd0, ifa.busy}, 32'd1);
    feed_a(19, 5, 7, 1'b0);
    chk("s4_trig_addr2", 32'(ifa.trig_addr), 32'd7);
    chk("s4_done2", {31'd0, ifa.done}, 32'd1);
    read_a(0, 1, 8);
    read_a(4, 1, 12);
    drain("s4b");

    // Reset in the middle of POST with a read outstanding.
    step_a(1'b0, 0, 1'b0, 1'b1);
    feed_a(12, 0, 6, 1'b0);
    ifa.rd_en = 1'b1;
    ifa.rd_offset = '0;
    step_a(1'b1, 12, 1'b0, 1'b0);
    ifa.rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s1_busy",      {31'd0, ifa.busy},     32'd0);
    chk("s1_done",      {31'd0, ifa.done},     32'd0);
    chk("s1_rd_valid",  {31'd0, ifa.rd_valid}, 32'd0);
    chk("s1_trig_addr", 32'(ifa.trig_addr),    32'd0);
    chk("s1_rd_data",   32'(ifa.rd_data),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step_a(1'b0, 0, 1'b0, 1'b1);
    feed_a(16, 100, 4, 1'b0);
    chk("s1_trig_addr_clean", 32'(ifa.trig_addr), 32'd4);
    chk("s1_done_clean", {31'd0, ifa.done}, 32'd1);
    read_a(0, 1, 100);
    read_a(15, 1, 115);
    drain("s1");

    // PRE_DEPTH = 0: trigger on the very first sample.
    step_b(1'b0, 0, 1'b0, 1'b1);
    step_b(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      step_b(1'b1, 50 + i, i == 0, 1'b0);
    chk("s5_trig_addr", 32'(ifb.trig_addr), 32'd0);
    chk("s5_done_early", {31'd0, ifb.done}, 32'd0);
    step_b(1'b1, 65, 1'b0, 1'b0);
    chk("s5_done", {31'd0, ifb.done}, 32'd1);
    read_b(0, 50);
    read_b(15, 65);
    drain("s5");

`ifdef WAVE_CAP_DECIM_EN
    // decim = 2: samples 0,3,6,... stored; ungated triggers ignored.
    ifa.decim = 8'd2;
    step_a(1'b0, 0, 1'b0, 1'b1);
    ifa.decim = 8'd0;
    for (int i = 0; i < 48; i++)
      step_a(1'b1, i, (i == 4) || (i == 13) || (i == 15), 1'b0);
    chk("s6_trig_addr", 32'(ifa.trig_addr), 32'd5);
    chk("s6_done_early", {31'd0, ifa.done}, 32'd0);
    step_a(1'b1, 48, 1'b0, 1'b0);
    chk("s6_done", {31'd0, ifa.done}, 32'd1);
    read_a(0, 1, 3);
    read_a(4, 1, 15);
    read_a(15, 1, 48);
    drain("s6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_capture_buf.md
# wave_capture_buf

Single-clock, parametrised triggered waveform capture buffer for the HDMI waveform display path. It records a stream of samples into an inferred simple-dual-port block RAM as a circular buffer, holding a programmable pre-trigger history. On trigger it finishes the post-trigger record, then freezes. The display renderer reads the frozen record by logical offset, starting from the oldest sample, without computing wrap addresses.

## Interface
- `DATA_W`, 8: sample width in bits.
- `ADDR_W`, 12: address width. Depth is `DEPTH = 2**ADDR_W`.
- `PRE_DEPTH`, 1024: samples kept before the trigger sample. Legal range is 0 .. `DEPTH-1`; an illegal value is an elaboration error.

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `arm`, input, 1: single-cycle start or restart of a capture.
- `sample_valid`, input, 1: `sample_din` is valid this cycle.
- `sample_din`, input, `DATA_W`: sample data.
- `trig`, input, 1: trigger qualifier. Sampled only together with `sample_valid`.
- `decim`, input, 8: decimation ratio minus 1. Present only with `WAVE_CAP_DECIM_EN`.
- `rd_en`, input, 1: read request.
- `rd_offset`, input, `ADDR_W`: logical offset, where 0 is the oldest sample of the record.
- `rd_data`, output, `DATA_W`: read data.
- `rd_valid`, output, 1: `rd_data` is valid.
- `busy`, output, 1: state is PRE, ARMED or POST.
- `done`, output, 1: record is complete and frozen.
- `trig_addr`, output, `ADDR_W`: physical address of the trigger sample.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- A sample is *accepted* on a clock edge when `sample_valid`=1, the state is PRE, ARMED or POST, and the decimation gate is open. An accepted sample is written at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
- IDLE or DONE -> PRE on `arm`. This clears `wr_ptr`, the pre-trigger counter, the post-trigger counter and the decimation counter, and deasserts `done`.
- PRE: count accepted samples. After `PRE_DEPTH` samples, go to ARMED. `trig` is ignored in PRE.
  - With `PRE_DEPTH`=0, PRE passes straight to ARMED on the next edge.
- ARMED: an accepted sample with `trig`=1 is the trigger sample.
  - Latch `trig_addr` = `wr_ptr`.
  - Load the post counter with `DEPTH-PRE_DEPTH-1`.
  - Go to POST, or to DONE if the count is 0.
- POST: each accepted sample decrements the post counter. The sample that brings it to 0 is the last one written, and the state goes to DONE.
- DONE: no writes. `done`=1 and the RAM contents are frozen.
- `arm` in any busy state restarts the capture exactly as from IDLE; the sample on that same edge is not written. `arm` has priority over `trig` and over completion on the same edge.
- Read address: `(trig_addr - PRE_DEPTH + rd_offset) mod DEPTH`, computed at `ADDR_W` width with natural wrap.
- Reads are honoured in every state; the data is meaningful only in DONE. A read and a write to the same address on one edge return the old data.
- Reset: state IDLE; `busy`, `done` and `rd_valid` are 0; `trig_addr` and `rd_data` are 0; all counters are 0. RAM contents are not cleared. Reset mid-capture aborts the capture.

## Timing
- Write: the sample is stored at the edge where it is accepted.
- `busy` and `done` are registered and change on the edge after the causing event.
  - `done` rises on the edge that writes the last post-trigger sample.
- Read latency: 1 cycle. `rd_en` at edge N gives `rd_data` and `rd_valid` at edge N+1.
  - `rd_valid` is a single pulse per request.
  - Back-to-back reads sustain one per cycle.
- `trig_addr` updates at the trigger edge and holds until the next `arm` or reset.
- Total record length is always `DEPTH` samples: `PRE_DEPTH` before, the trigger sample, and `DEPTH-PRE_DEPTH-1` after.

## Configuration
- `WAVE_CAP_DECIM_EN` defined:
  - The `decim` port exists.
  - The decimation counter opens the gate on every (`decim`+1)th valid sample, counting from the first valid sample after `arm`.
  - `trig` is qualified only on gated samples.
  - `decim` is sampled at `arm` and held for the whole capture.
- `WAVE_CAP_DECIM_EN` undefined: no `decim` port and no counter; every valid sample is accepted.

## Test plan
Scenarios 1-4 use `ADDR_W`=4 and `PRE_DEPTH`=4, with samples equal to their index from 0.
1. Reset in the middle of POST -> `busy`=0, `done`=0, `rd_valid`=0 and `trig_addr`=0 immediately. The next `arm` makes a clean capture.
2. `arm`; 22 valid samples with `trig` on sample 10 -> `trig_addr`=10, and `done` rises on the edge of sample 21. Readback:
   - `rd_offset` 0 returns 6.
   - `rd_offset` 4 returns 10.
   - `rd_offset` 15 returns 21, one cycle after `rd_en`.
3. `trig` held high from sample 0 -> trigger taken on sample 4, the first accepted sample in ARMED. `trig_addr`=4; `rd_offset` 0 returns 0.
4. `arm` during POST at sample 13 -> capture restarts. A new trigger at the 6th post-restart sample gives `trig_addr`=5. `arm` and `trig` on the same edge -> a restart and no trigger.
5. `PRE_DEPTH`=0 with `trig` on the first valid sample -> `trig_addr`=0, `rd_offset` 0 returns the trigger sample, and `done` is set after 16 samples.
6. With `WAVE_CAP_DECIM_EN` and `decim`=2 -> only samples 0, 3, 6, ... are stored, and `trig` on sample 4 is ignored.
